// File: rtl/cnt_dis_param.sv
// cnt_dis_param: prescaled N-digit hex/BCD up/down counter with parallel load,
// wrap pulse, and a time-multiplexed common-anode seven-segment driver.
module cnt_dis_param #(
  parameter int DIGITS   = 4,
  parameter int CNT_DIV  = 50000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                bcd,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                blank_lz,
  output logic [4*DIGITS-1:0] cnt,
  output logic                wrap,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (CNT_DIV  > 1) ? $clog2(CNT_DIV)  : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]   r_cpre;
  logic [SW-1:0]   r_spre;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_cnt;
  logic            r_wrap;
  logic [DIGITS-1:0] r_an;
  logic [6:0]      r_seg;

  logic            w_tick;
  logic [3:0]      w_nib [DIGITS];
  logic [W-1:0]    w_bcd_inc;
  logic [W-1:0]    w_bcd_dec;
  logic            w_cy;
  logic            w_bw;
  logic [DIGITS:0] w_hi_zero;
  logic [3:0]      w_sel_nib;
  logic            w_blank;
  logic [DIGITS-1:0] w_an;

  // Segment glyphs, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign w_nib[gi] = r_cnt[4*gi +: 4];
  end

  assign w_tick = en && (r_cpre == CNT_LAST);

  // BCD carry/borrow ripple and "this digit and everything above is zero" chain.
  // Nibbles >= 9 are treated as 9 on the way up so illegal codes A..F wrap to 0.
  always_comb begin
    w_bcd_inc = r_cnt;
    w_bcd_dec = r_cnt;
    w_cy      = 1'b1;
    w_bw      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_cy) begin
        if (w_nib[i] >= 4'd9) begin
          w_bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*i +: 4] = w_nib[i] + 4'd1;
          w_cy = 1'b0;
        end
      end
      if (w_bw) begin
        if (w_nib[i] == 4'd0) begin
          w_bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          w_bcd_dec[4*i +: 4] = w_nib[i] - 4'd1;
          w_bw = 1'b0;
        end
      end
    end
    w_hi_zero = '0;
    w_hi_zero[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_hi_zero[i] = w_hi_zero[i+1] && (w_nib[i] == 4'd0);
    end
  end

  assign w_sel_nib = w_nib[r_idx];
  assign w_blank   = blank_lz && (r_idx != '0) && w_hi_zero[r_idx];
  assign w_an      = ~(DIGITS'(1) << r_idx);

  // Count prescaler: free-runs while enabled, cleared by load so a tick follows a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpre <= '0;
    end else if (load) begin
      r_cpre <= '0;
    end else if (en) begin
      r_cpre <= w_tick ? '0 : r_cpre + CW'(1);
    end
  end

  // Counter and wrap pulse; load beats a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_cnt  <= load_val;
      r_wrap <= 1'b0;
    end else if (w_tick) begin
      case ({up, bcd})
        2'b10: begin
          r_cnt  <= r_cnt + W'(1);
          r_wrap <= &r_cnt;
        end
        2'b00: begin
          r_cnt  <= r_cnt - W'(1);
          r_wrap <= ~|r_cnt;
        end
        2'b11: begin
          r_cnt  <= w_bcd_inc;
          r_wrap <= w_cy;
        end
        default: begin
          r_cnt  <= w_bcd_dec;
          r_wrap <= w_bw;
        end
      endcase
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Scan prescaler and digit index, running continuously.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spre <= '0;
      r_idx  <= '0;
    end else if (r_spre == SCAN_LAST) begin
      r_spre <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_spre <= r_spre + SW'(1);
    end
  end

  // Registered display drive from the current index and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= w_an;
      r_seg <= w_blank ? 7'h7F : glyph(w_sel_nib);
    end
  end

  assign cnt  = r_cnt;
  assign wrap = r_wrap;
  assign an   = r_an;
  assign seg  = r_seg;

endmodule

// File: tb/tb_cnt_dis_param.sv
// Directed bench for cnt_dis_param with DIGITS=4, CNT_DIV=4, SCAN_DIV=2.
module tb_cnt_dis_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        bcd = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [15:0] cnt;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad = 0;

  cnt_dis_param #(.DIGITS(4), .CNT_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .bcd(bcd), .load(load),
    .load_val(load_val), .blank_lz(blank_lz), .cnt(cnt), .wrap(wrap),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ld(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    step(1);
    load = 1'b0;
  endtask

  logic [15:0] t3_exp [5] = '{16'h00C6, 16'h00C7, 16'h00C8, 16'h00C9, 16'h0100};
  logic [3:0]  t5_an  [8] = '{4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};
  logic [6:0]  t5_blk [8] = '{7'h24, 7'h19, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24};
  logic [6:0]  t5_shw [8] = '{7'h24, 7'h19, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h24};

  initial begin
    // reset state
    step(2);
    chk("rst_cnt", cnt, 16'h0000);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);

    // binary up counting, one tick per 4 clocks
    rst = 1'b0; en = 1'b1; up = 1'b1; bcd = 1'b0;
    step(3);
    chk("t1_pre", cnt, 16'h0000);
    step(1);
    chk("t1_c1", cnt, 16'h0001);
    step(4);
    chk("t1_c2", cnt, 16'h0002);
    ld(16'hFFFE);
    chk("t1_ld", cnt, 16'hFFFE);
    step(4);
    chk("t1_ffff", cnt, 16'hFFFF);
    chk("t1_nowrap", wrap, 1'b0);
    step(4);
    chk("t1_wrapcnt", cnt, 16'h0000);
    chk("t1_wrap", wrap, 1'b1);
    step(1);
    chk("t1_wrapclr", wrap, 1'b0);

    // binary down wrap
    up = 1'b0;
    ld(16'h0000);
    step(4);
    chk("t1_dn_cnt", cnt, 16'hFFFF);
    chk("t1_dn_wrap", wrap, 1'b1);
    up = 1'b1;

    // BCD carries, wraps and borrows
    bcd = 1'b1;
    ld(16'h0099);
    step(4);
    chk("t2_0100", cnt, 16'h0100);
    chk("t2_0100w", wrap, 1'b0);
    ld(16'h9999);
    step(4);
    chk("t2_wrapcnt", cnt, 16'h0000);
    chk("t2_wrap", wrap, 1'b1);
    up = 1'b0;
    step(4);
    chk("t2_dn9999", cnt, 16'h9999);
    chk("t2_dnwrap", wrap, 1'b1);
    ld(16'h0100);
    step(4);
    chk("t2_dn0099", cnt, 16'h0099);
    chk("t2_dn0099w", wrap, 1'b0);
    up = 1'b1;

    // illegal nibble C absorbed by carry
    ld(16'h00C5);
    for (int i = 0; i < 5; i++) begin
      step(4);
      chk($sformatf("t3_tick%0d", i), cnt, t3_exp[i]);
    end

    // load coincident with a tick
    ld(16'h0000);
    step(3);
    chk("t4_pre", cnt, 16'h0000);
    ld(16'h1234);
    chk("t4_ld", cnt, 16'h1234);
    step(3);
    chk("t4_hold", cnt, 16'h1234);
    step(1);
    chk("t4_next", cnt, 16'h1235);

    // scan and leading-zero blanking
    en = 1'b0; bcd = 1'b0; blank_lz = 1'b1; rst = 1'b1;
    step(1);
    rst = 1'b0;
    ld(16'h0042);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("t5b_an%0d", i), an, t5_an[i]);
      chk($sformatf("t5b_seg%0d", i), seg, t5_blk[i]);
    end
    blank_lz = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("t5s_an%0d", i), an, t5_an[i]);
      chk($sformatf("t5s_seg%0d", i), seg, t5_shw[i]);
    end
    chk("t5_cnt", cnt, 16'h0042);

    // reset mid-count, resume timing, enable freeze
    en = 1'b1; up = 1'b1;
    ld(16'h0005);
    step(2);
    rst = 1'b1;
    step(1);
    chk("t6_cnt", cnt, 16'h0000);
    chk("t6_wrap", wrap, 1'b0);
    chk("t6_an", an, 4'hF);
    chk("t6_seg", seg, 7'h7F);
    rst = 1'b0;
    step(3);
    chk("t6_pre", cnt, 16'h0000);
    step(1);
    chk("t6_resume", cnt, 16'h0001);
    en = 1'b0;
    step(20);
    chk("t6_frozen", cnt, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
